dsp_pipe_tap: RTL and testbench
===============================

Name: dsp_pipe_tap

Overview:
- Parametrised multi-stage pipeline register with a valid sideband and a runtime-selectable output tap (latency 0..DEPTH).
- Generalises the single-stage register/bypass select used on DSP48A1 operand and result paths (A, B, C, D, M, P, carry). Every path can share one block with latency chosen per instance and per run.
- Adds a synchronous clear, valid tracking, an in-flight count and out-of-range latency detection.

Parameters:
- WIDTH, 18, data width in bits (1..48).
- DEPTH, 4, number of physical register stages (1..8, checked against the package MAX_DEPTH).
- LAT_W, $clog2(DEPTH+1), width of lat_sel. Derived; must not be overridden.
- CNT_W, $clog2(DEPTH+1), width of inflight. Derived.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-low reset. Assertion clears all state immediately; release is synchronous to clk.
- ce, input, 1, clock enable; all stages advance together when ce=1.
- sclr, input, 1, synchronous clear of all stages; priority over ce.
- lat_sel, input, LAT_W, selected latency in cycles (0 = combinational bypass).
- in_valid, input, 1, in_data qualifier.
- in_data, input, WIDTH, data in.
- out_valid, output, 1, valid at the selected tap.
- out_data, output, WIDTH, data at the selected tap.
- inflight, output, CNT_W, number of set valid bits in stages 1..DEPTH.
- busy, output, 1, inflight != 0.
- lat_err, output, 1, lat_sel > DEPTH (combinational).

Behaviour:
- State: stage k (k=1..DEPTH) holds d[k] (WIDTH) and v[k] (1).
- Reset (rst=0, asynchronous): all d[k]=0, v[k]=0.
  - Resulting outputs: inflight=0, busy=0.
  - out_valid/out_data equal in_valid/in_data when the effective latency is 0; otherwise 0/0.
- Clock edge, in priority order:
  1. sclr=1: all d[k] and v[k] set to 0, regardless of ce.
  2. else ce=1: d[1]<=in_data, v[1]<=in_valid; d[k]<=d[k-1], v[k]<=v[k-1] for k>=2.
  3. else hold.
- Effective latency L = min(lat_sel, DEPTH).
  - lat_err = (lat_sel > DEPTH); out-of-range values clamp to DEPTH and are never undefined.
- Output mux (combinational):
  - L=0: out_data=in_data, out_valid=in_valid.
  - L>0: out_data=d[L], out_valid=v[L].
- Latency: with ce held high, a sample entering at edge n appears at the output after edge n+L-1, i.e. L cycles after it is presented.
- Stall: ce=0 freezes every stage. Data is neither lost nor duplicated.
- Changing lat_sel mid-stream takes effect immediately on the output mux. Stage contents are unaffected, so samples may be skipped or repeated at the tap; this is the caller's responsibility and is not flagged.
- inflight = popcount of v[1..DEPTH], registered view of current state, range 0..DEPTH. Unaffected by lat_sel.
- sclr and ce both high: the clear wins, and the in_data presented that cycle is discarded.
- rst asserted mid-stream: immediate clear. The first capture is on the first edge with rst=1 and ce=1.

Optional Feature:
- Macro: DSP_PIPE_TAP_HOLD_EN.
- Defined: a stage's data register loads only when ce=1 and its incoming valid is 1. For stage 1 the incoming valid is in_valid; for stage k it is v[k-1]. Valid bits still shift on every ce, and bubbles keep the last data (toggle/power reduction). out_data during out_valid=0 is therefore stale, not 0.
- Undefined: data shifts unconditionally with ce, as described in Behaviour.
- sclr and rst behaviour are identical in both builds.

Decomposition:
- Package dsp_pipe_pkg:
  - localparam MAX_DEPTH=8.
  - localparam MAX_WIDTH=48.
  - Popcount function for up to MAX_DEPTH bits.
- Sub-module dsp_pipe_stage: one data+valid register with ce, sclr, rst and the hold-enable logic. It is instantiated DEPTH times in a generate loop.
- The top level contains only the tap mux, clamp/lat_err and the inflight/busy logic.

Test Plan:
- Reset: WIDTH=18, DEPTH=4, drive in_data=0x3FFFF, ce=1, then rst=0 mid-cycle. Required: inflight=0 and busy=0 immediately; out_data=0 for lat_sel=1..4 without waiting for a clock edge.
- Latency sweep: ce=1, in_valid=1, in_data=1,2,3,… on consecutive cycles, lat_sel=3. Required: out_data=1 with out_valid=1 exactly 3 cycles after 1 is presented. Repeat for lat_sel=0 (same cycle) and lat_sel=4.
- Stall: stream 10,11,12 at lat_sel=2, then hold ce=0 for 3 cycles. Required: out_data holds at 10 and inflight holds at 2; ce=1 resumes with 11, then 12, with no loss or duplicates.
- Bubbles and count: pattern in_valid=1,0,1,1 at DEPTH=4. Required: inflight goes 1,1,2,3 and busy=1. Feeding in_valid=0 for 4 more cycles drains inflight to 0 and busy to 0.
- sclr vs ce: pipeline full (inflight=4), then sclr=1 and ce=1 with in_data=0x155, in_valid=1. Required: next cycle inflight=0 and out_valid=0 at lat_sel=1; 0x155 is not captured.
- lat_err: lat_sel=7 with DEPTH=4. Required: lat_err=1 and the output equals the lat_sel=4 tap. With DSP_PIPE_TAP_HOLD_EN defined, a bubble after 0x2A leaves d[1]=0x2A.

Source files
------------

// File: rtl/dsp_pipe_tap_pkg.sv
// rtl/dsp_pipe_tap_pkg.sv - shared limits and popcount helper for the tap pipeline
package dsp_pipe_pkg;

  localparam int MAX_DEPTH = 8;
  localparam int MAX_WIDTH = 48;
  localparam int POP_W     = $clog2(MAX_DEPTH + 1);

  // Number of set bits in a valid vector of up to MAX_DEPTH stages
  function automatic logic [POP_W-1:0] popcount(input logic [MAX_DEPTH-1:0] bits);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      n = n + POP_W'(bits[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/dsp_pipe_tap_if.sv
// rtl/dsp_pipe_tap_if.sv - data/valid stream bundle entering and leaving the tap pipeline
interface dsp_pipe_tap_if #(
  parameter int WIDTH = 18
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;

  // Producer/consumer side: drives the input sample, observes the tap
  modport master (
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_data
  );

  // Pipeline side: accepts the input sample, drives the tap
  modport slave (
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/dsp_pipe_tap_stage.sv
// rtl/dsp_pipe_tap_stage.sv - one data+valid register stage; DSP_PIPE_TAP_HOLD_EN makes bubbles keep old data
module dsp_pipe_stage
  import dsp_pipe_pkg::*;
#(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             sclr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("dsp_pipe_stage: WIDTH out of range");
  end

  logic load_data;

`ifdef DSP_PIPE_TAP_HOLD_EN
  // Data register only toggles when a real sample passes through
  assign load_data = ce & in_valid;
`else
  assign load_data = ce;
`endif

  // Stage register: clear wins over advance; valid always shifts with ce
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (sclr) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (ce) begin
        out_valid <= in_valid;
      end
      if (load_data) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/dsp_pipe_tap.sv
// rtl/dsp_pipe_tap.sv - multi-stage pipeline with runtime latency tap; optional DSP_PIPE_TAP_HOLD_EN
module dsp_pipe_tap
  import dsp_pipe_pkg::*;
#(
  parameter  int WIDTH = 18,
  parameter  int DEPTH = 4,
  localparam int LAT_W = $clog2(DEPTH + 1),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             sclr,
  input  logic [LAT_W-1:0] lat_sel,
  dsp_pipe_tap_if.slave    bus,
  output logic [CNT_W-1:0] inflight,
  output logic             busy,
  output logic             lat_err
);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_depth_check
    $error("dsp_pipe_tap: DEPTH out of range");
  end

  // Index 0 is the live input so that latency 0 is just another tap
  logic [DEPTH:0][WIDTH-1:0] d;
  logic [DEPTH:0]            v;
  logic [LAT_W-1:0]          eff_lat;
  logic [MAX_DEPTH-1:0]      v_bits;

  assign d[0] = bus.in_data;
  assign v[0] = bus.in_valid;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    dsp_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .sclr      (sclr),
      .in_valid  (v[k-1]),
      .in_data   (d[k-1]),
      .out_valid (v[k]),
      .out_data  (d[k])
    );
  end

  // Out-of-range selects clamp to the last stage rather than reading garbage
  always_comb begin
    lat_err = (lat_sel > LAT_W'(DEPTH));
    eff_lat = lat_err ? LAT_W'(DEPTH) : lat_sel;
  end

  // Tap mux over input and every stage
  always_comb begin
    bus.out_valid = v[0];
    bus.out_data  = d[0];
    for (int k = 1; k <= DEPTH; k++) begin
      if (eff_lat == LAT_W'(k)) begin
        bus.out_valid = v[k];
        bus.out_data  = d[k];
      end
    end
  end

  // Occupancy counts only registered stages, independent of the tap
  always_comb begin
    v_bits            = '0;
    v_bits[DEPTH-1:0] = v[DEPTH:1];
    inflight          = CNT_W'(popcount(v_bits));
    busy              = |v[DEPTH:1];
  end

endmodule

// File: tb/tb_dsp_pipe_tap.sv
// tb/tb_dsp_pipe_tap.sv - self-checking bench for dsp_pipe_tap against a sample-history model
module tb_dsp_pipe_tap;

  localparam int WIDTH = 18;
  localparam int DEPTH = 4;
  localparam int LAT_W = 3;
  localparam int CNT_W = 3;

  logic             clk     = 1'b0;
  logic             rst     = 1'b0;
  logic             ce      = 1'b0;
  logic             sclr    = 1'b0;
  logic [LAT_W-1:0] lat_sel = '0;
  logic [CNT_W-1:0] inflight;
  logic             busy;
  logic             lat_err;

  int n_tests = 0;
  int n_fail  = 0;

  dsp_pipe_tap_if #(.WIDTH(WIDTH)) bus ();

  dsp_pipe_tap #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .sclr     (sclr),
    .lat_sel  (lat_sel),
    .bus      (bus.slave),
    .inflight (inflight),
    .busy     (busy),
    .lat_err  (lat_err)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] d;
  } ent_t;

  // Every sample accepted since the last clear, newest first
  ent_t hist[$];
  ent_t new_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist.delete();
    end else if (sclr) begin
      hist.delete();
    end else if (ce) begin
      new_e.v = bus.in_valid;
      new_e.d = bus.in_data;
      hist.push_front(new_e);
      if (hist.size() > 64) void'(hist.pop_back());
    end
  end

  // Sample seen L cycles back; in hold builds data is the newest real sample that got that far
  function automatic ent_t model_tap(int L);
    ent_t r;
    r = '0;
    if (L == 0) begin
      r.v = bus.in_valid;
      r.d = bus.in_data;
      return r;
    end
    if (hist.size() >= L) r.v = hist[L-1].v;
`ifdef DSP_PIPE_TAP_HOLD_EN
    for (int i = L - 1; i < hist.size(); i++) begin
      if (hist[i].v) begin
        r.d = hist[i].d;
        break;
      end
    end
`else
    if (hist.size() >= L) r.d = hist[L-1].d;
`endif
    return r;
  endfunction

  function automatic int model_inflight();
    int n;
    n = 0;
    for (int i = 0; i < DEPTH && i < hist.size(); i++) begin
      if (hist[i].v) n++;
    end
    return n;
  endfunction

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    ent_t e;
    int   sel;
    int   eff;
    int   cnt;
    sel = int'(lat_sel);
    eff = (sel > DEPTH) ? DEPTH : sel;
    e   = model_tap(eff);
    cnt = model_inflight();
    chk("mon_out_valid", 32'(bus.out_valid), 32'(e.v));
    chk("mon_out_data",  32'(bus.out_data),  32'(e.d));
    chk("mon_inflight",  32'(inflight),      32'(cnt));
    chk("mon_busy",      32'(busy),          32'(cnt != 0));
    chk("mon_lat_err",   32'(lat_err),       32'(sel > DEPTH));
  end

  task automatic step(input logic s, input logic c, input logic vld, input logic [WIDTH-1:0] dat);
    @(posedge clk);
    #1;
    sclr         = s;
    ce           = c;
    bus.in_valid = vld;
    bus.in_data  = dat;
  endtask

  task automatic lat_run(input int L);
    lat_sel = LAT_W'(L);
    step(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 1'b1, WIDTH'(i + 1));
      #2;
      if (i == L) begin
        chk("lat_first_data",  32'(bus.out_data),  32'd1);
        chk("lat_first_valid", 32'(bus.out_valid), 32'd1);
      end
      if (i == L - 1) begin
        chk("lat_early_valid", 32'(bus.out_valid), 32'd0);
      end
    end
  endtask

  int pat[4];
  int exp_cnt[8];

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    pat     = '{1, 0, 1, 1};
    exp_cnt = '{1, 1, 2, 3, 2, 2, 1, 0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Reset asserted mid-cycle with a full pipe
    lat_sel = 3'd4;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 18'h3FFFF);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    for (int L = 1; L <= 4; L++) begin
      lat_sel = LAT_W'(L);
      #1;
      chk("rst_tap_data",  32'(bus.out_data),  32'd0);
      chk("rst_tap_valid", 32'(bus.out_valid), 32'd0);
    end
    lat_sel = 3'd0;
    #1;
    chk("rst_bypass_data", 32'(bus.out_data), 32'h3FFFF);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Latency sweep
    lat_run(3);
    lat_run(0);
    lat_run(4);

    // Stall
    lat_sel = 3'd2;
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 18'd10);
    step(1'b0, 1'b1, 1'b1, 18'd11);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, 18'd12);
      #2;
      chk("stall_data",     32'(bus.out_data),  32'd10);
      chk("stall_valid",    32'(bus.out_valid), 32'd1);
      chk("stall_inflight", 32'(inflight),      32'd2);
    end
    step(1'b0, 1'b1, 1'b1, 18'd12);
    step(1'b0, 1'b1, 1'b0, '0);
    #2;
    chk("resume_11", 32'(bus.out_data), 32'd11);
    step(1'b0, 1'b1, 1'b0, '0);
    #2;
    chk("resume_12",       32'(bus.out_data),  32'd12);
    chk("resume_12_valid", 32'(bus.out_valid), 32'd1);
    step(1'b0, 1'b1, 1'b0, '0);
    #2;
    chk("resume_drained_valid", 32'(bus.out_valid), 32'd0);

    // Bubbles and occupancy count
    lat_sel = 3'd1;
    step(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b1, (i < 4) ? pat[i][0] : 1'b0, WIDTH'(i + 5));
      #2;
      if (i >= 1) chk("bubble_inflight", 32'(inflight), 32'(exp_cnt[i-1]));
      if (i == 4) chk("bubble_busy", 32'(busy), 32'd1);
      if (i == 8) chk("drain_busy",  32'(busy), 32'd0);
    end

    // sclr beats ce
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, WIDTH'(32'h100 + i));
    step(1'b1, 1'b1, 1'b1, 18'h155);
    #2;
    chk("full_inflight", 32'(inflight), 32'd4);
    step(1'b0, 1'b0, 1'b0, '0);
    #2;
    chk("sclr_inflight", 32'(inflight),      32'd0);
    chk("sclr_valid",    32'(bus.out_valid), 32'd0);
    chk("sclr_data",     32'(bus.out_data),  32'd0);

    // Out-of-range latency clamps to the deepest tap
    step(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, WIDTH'(32'h21 + i));
    step(1'b0, 1'b0, 1'b0, '0);
    lat_sel = 3'd7;
    #1;
    chk("laterr_7",      32'(lat_err),       32'd1);
    chk("laterr_7_data", 32'(bus.out_data),  32'h21);
    chk("laterr_7_vld",  32'(bus.out_valid), 32'd1);
    lat_sel = 3'd4;
    #1;
    chk("laterr_4",      32'(lat_err),      32'd0);
    chk("laterr_4_data", 32'(bus.out_data), 32'h21);
    lat_sel = 3'd5;
    #1;
    chk("laterr_5", 32'(lat_err), 32'd1);
    lat_sel = 3'd3;
    #1;
    chk("tap3_data", 32'(bus.out_data), 32'h22);

    // Bubble after 0x2A: hold builds keep 0x2A in stage 1
    lat_sel = 3'd1;
    step(1'b0, 1'b1, 1'b1, 18'h2A);
    step(1'b0, 1'b1, 1'b0, 18'h03);
    step(1'b0, 1'b0, 1'b0, 18'h03);
    #2;
    chk("bubble_valid", 32'(bus.out_valid), 32'd0);
`ifdef DSP_PIPE_TAP_HOLD_EN
    chk("bubble_hold_data", 32'(bus.out_data), 32'h2A);
`else
    chk("bubble_shift_data", 32'(bus.out_data), 32'h03);
`endif

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 31) == 0, $urandom_range(0, 4) != 0,
           1'($urandom_range(0, 1)), WIDTH'($urandom));
      lat_sel = LAT_W'($urandom_range(0, 7));
      if (!rst) rst = 1'b1;
      if ($urandom_range(0, 199) == 0) begin
        #3;
        rst = 1'b0;
      end
    end

    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
